hilo_md_ctrl: RTL
=================

Name: hilo_md_ctrl

Overview:
- Sequencer for the EX-stage multi-cycle HI/LO operations (mult, multu, div, divu).
- Accepts one operation from EX and drives the shared multiplier and iterative divider, including their operands and handshakes.
- Raises the EX stall request until the 64-bit result is captured, then presents {hi, lo} for the HI/LO write path.
- Handles pipeline flush and downstream stall.

Parameters:
MUL_LAT, 2, multiplier latency in cycles (legal range 1..15); mul_result_i is valid MUL_LAT cycles after operands are applied.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  annul in-flight operation
ex_stall  in  1  downstream stall; EX cannot advance this cycle
op_valid  in  1  EX holds a HI/LO arithmetic instruction
md_op  in  4  one-hot {mult, multu, div, divu}
opdata_a  in  32  rs value
opdata_b  in  32  rt value
stallreq_o  out  1  EX stall request
result_valid_o  out  1  hi_o/lo_o valid for the current EX instruction
hi_o  out  32  HI result
lo_o  out  32  LO result
mul_signed_o  out  1  multiplier signed-mode select
mul_ina_o  out  32  multiplier operand A
mul_inb_o  out  32  multiplier operand B
mul_result_i  in  64  multiplier product
div_start_o  out  1  divider start
div_signed_o  out  1  divider signed-mode select
div_opdata1_o  out  32  dividend
div_opdata2_o  out  32  divisor
div_annul_o  out  1  divider abort
div_result_i  in  64  {remainder, quotient}
div_ready_i  in  1  divider result ready (one-cycle pulse)

Behaviour:
- Reset and clocking: one clock, clk. Reset is synchronous and active-high (rst). Reset forces IDLE and zeroes every output and register, including mid-operation.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE. The state register is 2 bits; the latency counter is 4 bits.
- IDLE:
  - op_valid & legal md_op & !flush: latch opdata_a/b and the signed flag (mult|div); stallreq_o=1 combinationally.
  - Next state is MUL_WAIT (counter loaded MUL_LAT-1) or DIV_WAIT.
  - md_op not one-hot, or zero: ignored, no stall.
- MUL_WAIT:
  - mul_* driven from the latched registers; stallreq_o=1.
  - Counter decrements each cycle. At count 0, capture hi=mul_result_i[63:32], lo=[31:0] and go to DONE.
  - Lasts exactly MUL_LAT cycles.
- DIV_WAIT:
  - div_opdata*/div_signed_o driven from the latched registers.
  - div_start_o = !div_ready_i (combinational); stallreq_o = !div_ready_i.
  - div_ready_i=1: capture hi=div_result_i[63:32] (remainder), lo=[31:0] (quotient), then go to DONE.
- DONE:
  - result_valid_o=1, stallreq_o=0, hi_o/lo_o held.
  - ex_stall=1: remain in DONE.
  - Otherwise go to IDLE next cycle. The EX instruction retires on this edge, so op_valid in the following IDLE cycle refers to a new instruction.
- Outside DONE: hi_o/lo_o/result_valid_o are 0. Outside their wait states, mul_*/div_* outputs are 0.
- Flush:
  - Any state goes to IDLE next cycle; the captured result is discarded and result_valid_o never asserts.
  - In DIV_WAIT, div_annul_o=1 for that cycle and div_start_o=0.
  - Flush has priority over div_ready_i, the counter reaching 0, and a new op_valid.
- Back-to-back operations: minimum one IDLE cycle between operations. No overlap; single outstanding operation.
- Latency from IDLE accept to result_valid_o:
  - mult: MUL_LAT+1 cycles.
  - div: (cycles to div_ready_i)+1 cycles.

Optional Feature:
HILO_MD_DIV0_FAST_EN
- Defined: div/divu with opdata_b==0 accepted in IDLE bypasses the divider.
  - Goes directly to DONE with hi=opdata_a, lo=32'hFFFF_FFFF.
  - div_start_o is never asserted; stallreq_o is high for the accept cycle only.
- Undefined: a zero divisor is sent to the divider like any other divide.

Test Plan:
- Reset mid-DIV_WAIT: rst=1 for one cycle -> next cycle state IDLE, all outputs 0, div_start_o=0.
- multu, MUL_LAT=2, a=32'hFFFF_FFFF, b=2 -> stallreq_o high for 3 cycles; 4th cycle result_valid_o=1, hi_o=1, lo_o=32'hFFFF_FFFE.
- div signed, a=-7, b=2, divider ready after 33 cycles -> div_start_o high until ready; DONE shows hi_o=32'hFFFF_FFFF (-1), lo_o=32'hFFFF_FFFD (-3).
- DONE with ex_stall=1 for 3 cycles -> result_valid_o and hi_o/lo_o stable for 4 cycles; no restart with op_valid still high.
- flush asserted in the same cycle as div_ready_i -> div_annul_o=1, result_valid_o never asserts, IDLE next cycle.
- HILO_MD_DIV0_FAST_EN defined, divu a=5, b=0 -> div_start_o never asserts; next cycle hi_o=5, lo_o=32'hFFFF_FFFF.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// ============================================================================
// hilo_md_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequencer for the EX-stage multi-cycle HI/LO operations (mult, multu,
//   div, divu). One operation is accepted from EX at a time. The block drives
//   the shared multiplier and the iterative divider, holds the EX stall
//   request until the 64-bit result has been captured, and then presents
//   {hi, lo} to the HI/LO write path while the instruction sits in EX.
//
// Parameters:
//   MUL_LAT          multiplier latency in cycles (legal range 1..15). The
//                    product on mul_result_i is taken in the MUL_LAT-th cycle
//                    that the operands are presented.
//
// Configuration macro:
//   HILO_MD_DIV0_FAST_EN  when defined, div/divu with a zero divisor skips the
//                         divider and completes directly with
//                         hi = dividend, lo = 32'hFFFF_FFFF.
//                         When undefined, a zero divisor goes to the divider
//                         like any other divide.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   flush            annul the in-flight operation
//   ex_stall         downstream stall; EX cannot advance this cycle
//   op_valid         EX holds a HI/LO arithmetic instruction
//   md_op[3:0]       one-hot {mult, multu, div, divu}
//   opdata_a[31:0]   rs value
//   opdata_b[31:0]   rt value
//   stallreq_o       EX stall request
//   result_valid_o   hi_o/lo_o valid for the current EX instruction
//   hi_o[31:0]       HI result
//   lo_o[31:0]       LO result
//   mul_signed_o     multiplier signed-mode select
//   mul_ina_o[31:0]  multiplier operand A
//   mul_inb_o[31:0]  multiplier operand B
//   mul_result_i     multiplier product (64 bits)
//   div_start_o      divider start
//   div_signed_o     divider signed-mode select
//   div_opdata1_o    dividend
//   div_opdata2_o    divisor
//   div_annul_o      divider abort
//   div_result_i     divider result {remainder, quotient}
//   div_ready_i      divider result ready (one-cycle pulse)
// ============================================================================
module hilo_md_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        op_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] opdata_a,
    input  logic [31:0] opdata_b,
    output logic        stallreq_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_ina_o,
    output logic [31:0] mul_inb_o,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // The counter is loaded with MUL_LAT-1 and the product is taken when it
    // reaches zero, so MUL_WAIT lasts exactly MUL_LAT cycles.
    localparam logic [3:0] LP_MUL_CNT_INIT = 4'(MUL_LAT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    state_t      w_nextState;
    logic [3:0]  w_nextCnt;
    logic [31:0] w_nextOpA;
    logic [31:0] w_nextOpB;
    logic        w_nextSigned;
    logic [31:0] w_nextHi;
    logic [31:0] w_nextLo;

    logic        w_legalOp;
    logic        w_isMul;
    logic        w_isSigned;
    logic        w_accept;
    logic        w_div0Fast;

    // Decode of the incoming request. An op code that is zero or has more than
    // one bit set is not a HI/LO arithmetic instruction and is ignored. The
    // signed flag is shared by both units: mult and div are the signed forms.
    assign w_legalOp  = (md_op != 4'd0) && ((md_op & (md_op - 4'd1)) == 4'd0);
    assign w_isMul    = md_op[3] | md_op[2];
    assign w_isSigned = md_op[3] | md_op[1];

    // Flush wins over a new request, so nothing is accepted in a flush cycle.
    assign w_accept   = (r_state == S_IDLE) && op_valid && w_legalOp && !flush;

`ifdef HILO_MD_DIV0_FAST_EN
    // A zero divisor has a fixed answer, so the divider is not worth waiting on.
    assign w_div0Fast = !w_isMul && (opdata_b == 32'd0);
`else
    assign w_div0Fast = 1'b0;
`endif

    // State and datapath registers. Reset clears everything, even in the middle
    // of an operation; the divider is not annulled by reset because it shares
    // the same reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_opA    <= 32'd0;
            r_opB    <= 32'd0;
            r_signed <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_opA    <= w_nextOpA;
            r_opB    <= w_nextOpB;
            r_signed <= w_nextSigned;
            r_hi     <= w_nextHi;
            r_lo     <= w_nextLo;
        end
    end

    // Next-state and output decode. All unit-facing outputs are zero outside
    // the state that owns that unit, and hi_o/lo_o are only exposed in DONE,
    // so stale captured values never leak onto the HI/LO write path.
    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_nextOpA      = r_opA;
        w_nextOpB      = r_opB;
        w_nextSigned   = r_signed;
        w_nextHi       = r_hi;
        w_nextLo       = r_lo;

        stallreq_o     = 1'b0;
        result_valid_o = 1'b0;
        hi_o           = 32'd0;
        lo_o           = 32'd0;
        mul_signed_o   = 1'b0;
        mul_ina_o      = 32'd0;
        mul_inb_o      = 32'd0;
        div_start_o    = 1'b0;
        div_signed_o   = 1'b0;
        div_opdata1_o  = 32'd0;
        div_opdata2_o  = 32'd0;
        div_annul_o    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // The stall must be raised in the accept cycle itself so
                    // EX holds the instruction while the operands are latched.
                    stallreq_o   = 1'b1;
                    w_nextOpA    = opdata_a;
                    w_nextOpB    = opdata_b;
                    w_nextSigned = w_isSigned;
                    if (w_isMul) begin
                        w_nextCnt   = LP_MUL_CNT_INIT;
                        w_nextState = S_MUL_WAIT;
                    end else if (w_div0Fast) begin
                        w_nextHi    = opdata_a;
                        w_nextLo    = 32'hFFFF_FFFF;
                        w_nextState = S_DONE;
                    end else begin
                        w_nextState = S_DIV_WAIT;
                    end
                end
            end

            S_MUL_WAIT: begin
                stallreq_o   = 1'b1;
                mul_signed_o = r_signed;
                mul_ina_o    = r_opA;
                mul_inb_o    = r_opB;
                if (flush) begin
                    w_nextState = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_nextHi    = mul_result_i[63:32];
                    w_nextLo    = mul_result_i[31:0];
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end

            S_DIV_WAIT: begin
                div_signed_o  = r_signed;
                div_opdata1_o = r_opA;
                div_opdata2_o = r_opB;
                stallreq_o    = !div_ready_i;
                if (flush) begin
                    // Abort the divider; a ready pulse in the same cycle is
                    // dropped along with the instruction.
                    div_annul_o = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    // Start is held until the divider answers; the divider
                    // ignores it while busy.
                    div_start_o = !div_ready_i;
                    if (div_ready_i) begin
                        w_nextHi    = div_result_i[63:32];
                        w_nextLo    = div_result_i[31:0];
                        w_nextState = S_DONE;
                    end
                end
            end

            S_DONE: begin
                result_valid_o = 1'b1;
                hi_o           = r_hi;
                lo_o           = r_lo;
                // The instruction retires on the edge that leaves DONE, so a
                // still-high op_valid here is the same instruction and must
                // not start another operation.
                if (flush || !ex_stall) begin
                    w_nextState = S_IDLE;
                end
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule
